data_mem_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 (pipeline
//   MEM stage) and port 1 (loader/DMA). Round-robin grant, one transaction at a

---
 rtl/data_mem_arbiter_if.sv | 45 ++++
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the data memory.
// slave is the arbiter's view; master is the requesters'/memory's view.
interface data_mem_arbiter_if;
    logic        m0Req;
    logic        m0Write;
    logic [31:0] m0Adr;
    logic [31:0] m0WData;
    logic        m0Rdy;
    logic        m0Err;

    logic        m1Req;
    logic        m1Write;
    logic [31:0] m1Adr;
    logic [31:0] m1WData;
    logic        m1Rdy;
    logic        m1Err;

    logic [31:0] rData;
    logic        busy;
    logic        grant;

    logic [31:0] memAdr;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readData;

    modport slave (
        input  m0Req, m0Write, m0Adr, m0WData,
        input  m1Req, m1Write, m1Adr, m1WData,
        input  readData,
        output m0Rdy, m0Err, m1Rdy, m1Err,
        output rData, busy, grant,
        output memAdr, writeData, memRead, memWrite
    );

    modport master (
        output m0Req, m0Write, m0Adr, m0WData,
        output m1Req, m1Write, m1Adr, m1WData,
        output readData,
        input  m0Rdy, m0Err, m1Rdy, m1Err,
        input  rData, busy, grant,
        input  memAdr, writeData, memRead, memWrite
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the pipeline
// MEM stage (port 0) and the loader/DMA (port 1), one transaction at a time.
module data_mem_arbiter #(
    parameter logic [31:0] BASE_ADR      = 32'd1024,
    parameter int          DEPTH_WORDS   = 64,
    parameter int          ACCESS_CYCLES = 1
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateT;

    localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    // One extra bit so the end of the window cannot wrap past 2^32.
    localparam logic [32:0]      END_ADR  = {1'b0, BASE_ADR} + 33'(4 * DEPTH_WORDS);

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic             lastGrant;
    logic             latWrite;

    logic             anyReq;
    logic             pickPort;
    logic             pickWrite;
    logic [31:0]      pickAdr;
    logic [31:0]      pickWData;
    logic             adrValid;

    // Choose the winner among the current requests and qualify its address.
    always_comb begin
        anyReq    = bus.m0Req | bus.m1Req;
        pickPort  = 1'b0;
        if (bus.m0Req && bus.m1Req) begin
            pickPort = ~lastGrant;
        end else begin
            pickPort = bus.m1Req;
        end
        pickWrite = pickPort ? bus.m1Write : bus.m0Write;
        pickAdr   = pickPort ? bus.m1Adr   : bus.m0Adr;
        pickWData = pickPort ? bus.m1WData : bus.m0WData;
        adrValid  = (pickAdr[1:0] == 2'b00) &&
                    ({1'b0, pickAdr} >= {1'b0, BASE_ADR}) &&
                    ({1'b0, pickAdr} <  END_ADR);
    end

    // Transaction sequencer: every output is registered here, so strobes and
    // ready pulses follow the state directly and drop at once on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lastGrant     <= 1'b1;
            latWrite      <= 1'b0;
            bus.grant     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.memAdr    <= '0;
            bus.writeData <= '0;
            bus.memRead   <= 1'b0;
            bus.memWrite  <= 1'b0;
            bus.m0Rdy     <= 1'b0;
            bus.m1Rdy     <= 1'b0;
            bus.m0Err     <= 1'b0;
            bus.m1Err     <= 1'b0;
            bus.rData     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        bus.grant     <= pickPort;
                        lastGrant     <= pickPort;
                        latWrite      <= pickWrite;
                        bus.busy      <= 1'b1;
                        bus.memAdr    <= pickAdr;
                        bus.writeData <= pickWData;
                        if (adrValid) begin
                            state        <= BUSY;
                            cnt          <= '0;
                            bus.memRead  <= ~pickWrite;
                            bus.memWrite <= pickWrite;
                        end else begin
                            // Bad address: answer straight away, memory untouched.
                            state     <= DONE;
                            bus.m0Rdy <= ~pickPort;
                            bus.m1Rdy <= pickPort;
                            bus.m0Err <= ~pickPort;
                            bus.m1Err <= pickPort;
                            bus.rData <= '0;
                        end
                    end
                end

                BUSY: begin
                    bus.memWrite <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        bus.memRead <= 1'b0;
                        bus.rData   <= latWrite ? 32'h0 : bus.readData;
                        bus.m0Rdy   <= ~bus.grant;
                        bus.m1Rdy   <= bus.grant;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.m0Rdy <= 1'b0;
                    bus.m1Rdy <= 1'b0;
                    bus.m0Err <= 1'b0;
                    bus.m1Err <= 1'b0;
                    bus.rData <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: directed vectors and corner sequences on two arbiter
// instances (1 and 3 access cycles), then random traffic against a schedule model.
module tb_data_mem_arbiter;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          DEPTH = 64;
    localparam int          ACC_A = 1;
    localparam int          ACC_B = 3;

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        expErr;
        logic [31:0] expData;
        int          expLat;
        int          expRd;
        int          expWr;
    } vecT;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    always #5 clk = ~clk;

    data_mem_arbiter_if busA ();
    data_mem_arbiter_if busB ();

    data_mem_arbiter #(.BASE_ADR(BASE), .DEPTH_WORDS(DEPTH), .ACCESS_CYCLES(ACC_A))
        dutA (.clk(clk), .rst(rstA), .bus(busA));
    data_mem_arbiter #(.BASE_ADR(BASE), .DEPTH_WORDS(DEPTH), .ACCESS_CYCLES(ACC_B))
        dutB (.clk(clk), .rst(rstB), .bus(busB));

    logic [31:0] memA [DEPTH];
    logic [31:0] memB [DEPTH];

    int nChecks = 0;
    int nFail   = 0;

    function automatic logic [31:0] initVal(int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
    endfunction

    function automatic bit adrOk(logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a[1:0] == 2'b00) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic logic [31:0] randAdr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            4:          return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            5:          return 32'($urandom_range(0, 1023));
            6:          return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            default:    return 32'hFFFFFFFC - 32'(4 * $urandom_range(0, 3));
        endcase
    endfunction

    // Behavioural data memories: combinational read, write on strobe, refilled during reset.
    assign busA.readData = memA[busA.memAdr[7:2]];
    assign busB.readData = memB[busB.memAdr[7:2]];

    always @(posedge clk) begin
        if (rstA) begin
            for (int i = 0; i < DEPTH; i++) memA[i] <= initVal(i);
        end else if (busA.memWrite) begin
            memA[busA.memAdr[7:2]] <= busA.writeData;
        end
        if (rstB) begin
            for (int i = 0; i < DEPTH; i++) memB[i] <= initVal(i);
        end else if (busB.memWrite) begin
            memB[busB.memAdr[7:2]] <= busB.writeData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic wr,
                                 input logic [31:0] adr, input logic [31:0] wd);
        if (port == 0) begin
            busA.m0Req = req; busA.m0Write = wr; busA.m0Adr = adr; busA.m0WData = wd;
        end else begin
            busA.m1Req = req; busA.m1Write = wr; busA.m1Adr = adr; busA.m1WData = wd;
        end
    endtask

    task automatic runVec(input vecT v, input int idx);
        int          lat;
        int          nRd;
        int          nWr;
        int          other;
        logic        err;
        logic [31:0] data;
        lat = -1; nRd = 0; nWr = 0; other = 0; err = 1'b0; data = '0;
        applyStimulus(v.port, 1'b1, v.wr, v.adr, v.wd);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            nRd += int'(busA.memRead);
            nWr += int'(busA.memWrite);
            if ((v.port == 0) ? busA.m1Rdy : busA.m0Rdy) other++;
            if ((v.port == 0) ? busA.m0Rdy : busA.m1Rdy) begin
                lat  = c;
                err  = (v.port == 0) ? busA.m0Err : busA.m1Err;
                data = busA.rData;
                break;
            end
        end
        applyStimulus(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput($sformatf("vec%0d latency", idx), lat, v.expLat);
        checkOutput($sformatf("vec%0d err", idx), err, v.expErr);
        checkOutput($sformatf("vec%0d rData", idx), data, v.expData);
        checkOutput($sformatf("vec%0d memRead cycles", idx), nRd, v.expRd);
        checkOutput($sformatf("vec%0d memWrite cycles", idx), nWr, v.expWr);
        checkOutput($sformatf("vec%0d other port rdy", idx), other, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecT         vecs[$];
        int          got0, got1, overlap, idleCnt, lat, nRd, nRdy;
        int          order[$];
        int          rdyCyc[$];
        logic [31:0] data;
        logic [31:0] mMem [DEPTH];
        int          mLast, e, gEdge, rEdge, cPort;
        bit          act, cWr, cValid, inBusy, inDone;
        logic [31:0] cAdr, cWd, cRd;
        bit          pend [2];

        vecs.push_back(vecT'{0, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1});
        vecs.push_back(vecT'{0, 1'b0, 32'h400, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0});
        vecs.push_back(vecT'{1, 1'b0, 32'h3FC, 32'h0, 1'b1, 32'h0, 1, 0, 0});
        vecs.push_back(vecT'{1, 1'b0, 32'h500, 32'h0, 1'b1, 32'h0, 1, 0, 0});
        vecs.push_back(vecT'{1, 1'b0, 32'h402, 32'h0, 1'b1, 32'h0, 1, 0, 0});
        vecs.push_back(vecT'{1, 1'b1, 32'h4FC, 32'h12345678, 1'b0, 32'h0, 2, 0, 1});
        vecs.push_back(vecT'{0, 1'b0, 32'h4FC, 32'h0, 1'b0, 32'h12345678, 2, 1, 0});
        vecs.push_back(vecT'{0, 1'b1, 32'hFFFFFFFC, 32'hBAD0BAD0, 1'b1, 32'h0, 1, 0, 0});
        vecs.push_back(vecT'{1, 1'b0, 32'h400, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0});
        vecs.push_back(vecT'{0, 1'b1, 32'h401, 32'h55555555, 1'b1, 32'h0, 1, 0, 0});
        vecs.push_back(vecT'{1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 0});

        rstA = 1'b1;
        rstB = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        busB.m0Req = 1'b0; busB.m0Write = 1'b0; busB.m0Adr = '0; busB.m0WData = '0;
        busB.m1Req = 1'b0; busB.m1Write = 1'b0; busB.m1Adr = '0; busB.m1WData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        checkOutput("reset m0Rdy", busA.m0Rdy, 0);
        checkOutput("reset m1Rdy", busA.m1Rdy, 0);
        checkOutput("reset m0Err", busA.m0Err, 0);
        checkOutput("reset m1Err", busA.m1Err, 0);
        checkOutput("reset rData", busA.rData, 0);
        checkOutput("reset busy", busA.busy, 0);
        checkOutput("reset grant", busA.grant, 0);
        checkOutput("reset memAdr", busA.memAdr, 0);
        checkOutput("reset writeData", busA.writeData, 0);
        checkOutput("reset memRead", busA.memRead, 0);
        checkOutput("reset memWrite", busA.memWrite, 0);
        checkOutput("reset B busy", busB.busy, 0);
        rstA = 1'b0;
        rstB = 1'b0;

        // Simultaneous requests straight out of reset: port 0 first, port 1 waits.
        applyStimulus(0, 1'b1, 1'b0, BASE + 32'd4, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, BASE + 32'd8, 32'h0);
        got0 = -1; got1 = -1; overlap = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (busA.m0Rdy && busA.m1Rdy) overlap++;
            if (busA.m0Rdy && got0 < 0) begin
                got0 = c;
                checkOutput("tie m0 rData", busA.rData, initVal(1));
                checkOutput("tie m0 grant", busA.grant, 0);
                applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (busA.m1Rdy && got1 < 0) begin
                got1 = c;
                checkOutput("tie m1 rData", busA.rData, initVal(2));
                checkOutput("tie m1 grant", busA.grant, 1);
                applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        checkOutput("tie m0 latency", got0, 2);
        checkOutput("tie m1 latency", got1, 5);
        checkOutput("tie overlap", overlap, 0);

        // Both ports hold requests: grants must alternate with one idle cycle between.
        applyStimulus(0, 1'b1, 1'b0, BASE + 32'd12, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, BASE + 32'd16, 32'h0);
        idleCnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (order.size() > 0 && order.size() < 6 && !busA.busy) idleCnt++;
            if (busA.m0Rdy) begin order.push_back(0); rdyCyc.push_back(c); end
            if (busA.m1Rdy) begin order.push_back(1); rdyCyc.push_back(c); end
            if (order.size() >= 6) break;
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rr completions", order.size(), 6);
        for (int i = 0; i < order.size(); i++)
            checkOutput($sformatf("rr grant %0d", i), order[i], i % 2);
        for (int i = 1; i < rdyCyc.size(); i++)
            checkOutput($sformatf("rr spacing %0d", i), rdyCyc[i] - rdyCyc[i-1], ACC_A + 2);
        checkOutput("rr idle cycles", idleCnt, 5);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], i);

        // Fields changed mid-access must not disturb the latched write.
        applyStimulus(0, 1'b1, 1'b1, BASE + 32'd16, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1, BASE + 32'd20, 32'h22222222);
        #1;
        checkOutput("latch memWrite", busA.memWrite, 1);
        checkOutput("latch memAdr", busA.memAdr, BASE + 32'd16);
        checkOutput("latch writeData", busA.writeData, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        checkOutput("latch m0Rdy", busA.m0Rdy, 1);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("latch mem[4]", memA[4], 32'h11111111);
        checkOutput("latch mem[5]", memA[5], initVal(5));

        // Three-cycle access on the last word, then a reset abort mid-access.
        busB.m0Req = 1'b1; busB.m0Write = 1'b0; busB.m0Adr = BASE + 32'd252;
        lat = -1; nRd = 0; data = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            nRd += int'(busB.memRead);
            if (busB.m0Rdy) begin lat = c; data = busB.rData; break; end
        end
        busB.m0Req = 1'b0;
        checkOutput("slow latency", lat, ACC_B + 1);
        checkOutput("slow memRead cycles", nRd, ACC_B);
        checkOutput("slow rData", data, initVal(63));
        @(posedge clk);
        @(negedge clk);
        busB.m1Req = 1'b1; busB.m1Write = 1'b0; busB.m1Adr = BASE;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort memRead before", busB.memRead, 1);
        @(posedge clk);
        @(negedge clk);
        rstB = 1'b1;
        #1;
        checkOutput("abort memRead", busB.memRead, 0);
        checkOutput("abort busy", busB.busy, 0);
        checkOutput("abort m1Rdy", busB.m1Rdy, 0);
        busB.m1Req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstB = 1'b0;
        nRdy = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            nRdy += int'(busB.m0Rdy | busB.m1Rdy);
        end
        checkOutput("abort no rdy", nRdy, 0);

        // Random traffic: the model schedules each transaction by edge arithmetic.
        rstA = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstA = 1'b0;
        for (int i = 0; i < DEPTH; i++) mMem[i] = initVal(i);
        mLast = 1; e = 0; act = 0; gEdge = 0; rEdge = 0; cPort = 0;
        cWr = 0; cValid = 0; cAdr = '0; cWd = '0; cRd = '0;
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            e++;
            if ((!act || e >= rEdge + 2) && (busA.m0Req || busA.m1Req)) begin
                cPort = (busA.m0Req && busA.m1Req) ? 1 - mLast : (busA.m1Req ? 1 : 0);
                mLast = cPort;
                cWr   = (cPort == 0) ? busA.m0Write : busA.m1Write;
                cAdr  = (cPort == 0) ? busA.m0Adr   : busA.m1Adr;
                cWd   = (cPort == 0) ? busA.m0WData : busA.m1WData;
                cValid = adrOk(cAdr);
                gEdge = e;
                rEdge = e + (cValid ? ACC_A : 0);
                act   = 1;
                if (cValid && cWr) mMem[cAdr[7:2]] = cWd;
                cRd = (cValid && !cWr) ? mMem[cAdr[7:2]] : 32'h0;
            end
            @(negedge clk);
            inBusy = act && cValid && e >= gEdge && e < rEdge;
            inDone = act && e == rEdge;
            checkOutput("rnd busy", busA.busy, inBusy || inDone);
            checkOutput("rnd m0Rdy", busA.m0Rdy, inDone && cPort == 0);
            checkOutput("rnd m1Rdy", busA.m1Rdy, inDone && cPort == 1);
            checkOutput("rnd m0Err", busA.m0Err, inDone && cPort == 0 && !cValid);
            checkOutput("rnd m1Err", busA.m1Err, inDone && cPort == 1 && !cValid);
            checkOutput("rnd memRead", busA.memRead, inBusy && !cWr);
            checkOutput("rnd memWrite", busA.memWrite, inBusy && cWr && e == gEdge);
            if (inBusy || inDone) checkOutput("rnd grant", busA.grant, cPort);
            if (inDone) checkOutput("rnd rData", busA.rData, cRd);
            if (inBusy) checkOutput("rnd memAdr", busA.memAdr, cAdr);
            if (inBusy && cWr) checkOutput("rnd writeData", busA.writeData, cWd);
            for (int p = 0; p < 2; p++) begin
                if (inDone && cPort == p) begin
                    pend[p] = 0;
                    applyStimulus(p, 1'b0, 1'b0, 32'h0, 32'h0);
                end
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p] = 1;
                    applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), randAdr(), $urandom);
                end else if (pend[p] && inBusy && cPort == p && $urandom_range(0, 1) == 1) begin
                    applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), randAdr(), $urandom);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
